// File: rtl/fsm_ctl.sv
// -----------------------------------------------------------------------------
// fsm_ctl : instruction sequencer for a small 16-bit core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) ->
// PCUPD. Memory waits are bounded by TIMEOUT cycles; a HALT opcode or a memory
// timeout parks the sequencer in STOP until reset.
//
// Parameters
//   PC_BITS  width of the PC this block sequences (must be >= 2)
//   TIMEOUT  max cycles to wait for mem_ack (1-255)
//
// Ports
//   clka           in   clock, rising edge active
//   reset          in   asynchronous active-low reset
//   run            in   level; start/continue execution
//   mem_ack        in   memory completion, honoured only in FETCH and MEM
//   instr[15:0]    in   instruction word, opcode = instr[15:12]
//   zero_flag      in   ALU zero flag, captured in EXEC
//   pc_latch_data  out  one-cycle PC update strobe (PCUPD)
//   pc_ctl[1:0]    out  next-PC source: 00 PC+2, 01 PC+imm, 10 sr1
//   ir_load        out  instruction register load (FETCH with mem_ack)
//   mem_req        out  memory request (FETCH, MEM)
//   mem_we         out  memory write (MEM for STORE)
//   rf_we          out  register-file write (WB)
//   halted, error  out  sticky status flags
//   state[2:0]     out  current state encoding
// -----------------------------------------------------------------------------
module fsm_ctl #(
  parameter int PC_BITS = 6,
  parameter int TIMEOUT = 15
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ack,
  input  logic [15:0] instr,
  input  logic        zero_flag,
  output logic        pc_latch_data,
  output logic [1:0]  pc_ctl,
  output logic        ir_load,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic        halted,
  output logic        error,
  output logic [2:0]  state
);

  // Reject parameter values the sequencer cannot honour.
  if (PC_BITS < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("fsm_ctl: PC_BITS must be >= 2 and TIMEOUT in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_STOP   = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BZ    = 4'h4;
  localparam logic [3:0] OP_JR    = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] opcode_r;
  logic       zf_r;
  logic [7:0] wait_cnt_r;
  logic       halted_r;
  logic       error_r;
  logic       set_halt_s;
  logic       set_err_s;
  logic       mem_wait_s;
  logic       timeout_s;
  logic       fetch_ack_s;
  logic       wait_entry_s;

  // mem_ack only matters while a request is outstanding.
  assign mem_wait_s   = (state_r == S_FETCH) || (state_r == S_MEM);
  assign fetch_ack_s  = (state_r == S_FETCH) && mem_ack;
  // Timeout fires on the cycle the counter would reach TIMEOUT; a same-cycle ack wins.
  assign timeout_s    = mem_wait_s && !mem_ack && ((wait_cnt_r + 8'd1) == TIMEOUT_CNT);
  assign wait_entry_s = ((state_s == S_FETCH) || (state_s == S_MEM)) && (state_s != state_r);

  // Next-state selection and sticky-flag set requests.
  always_comb begin
    state_s    = state_r;
    set_halt_s = 1'b0;
    set_err_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) state_s = S_FETCH;
        else     state_s = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_s = S_DECODE;
        end else if (timeout_s) begin
          state_s   = S_STOP;
          set_err_s = 1'b1;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: state_s = S_EXEC;
      S_EXEC: begin
        case (opcode_r)
          OP_ALU:            state_s = S_WB;
          OP_LOAD, OP_STORE: state_s = S_MEM;
          OP_HALT: begin
            state_s    = S_STOP;
            set_halt_s = 1'b1;
          end
          default:           state_s = S_PCUPD;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (opcode_r == OP_LOAD) state_s = S_WB;
          else                     state_s = S_PCUPD;
        end else if (timeout_s) begin
          state_s   = S_STOP;
          set_err_s = 1'b1;
        end else begin
          state_s = S_MEM;
        end
      end
      S_WB: state_s = S_PCUPD;
      S_PCUPD: begin
        if (run) state_s = S_FETCH;
        else     state_s = S_IDLE;
      end
      S_STOP:  state_s = S_STOP;
      default: state_s = S_IDLE;
    endcase
  end

  // State register, latched opcode / zero flag, wait counter and sticky flags.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      opcode_r   <= OP_NOP;
      zf_r       <= 1'b0;
      wait_cnt_r <= 8'd0;
      halted_r   <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (fetch_ack_s) opcode_r <= instr[15:12];
      if (state_r == S_EXEC) zf_r <= zero_flag;
      if (wait_entry_s) begin
        wait_cnt_r <= 8'd0;
      end else if (mem_wait_s && !mem_ack) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
      if (set_halt_s) halted_r <= 1'b1;
      if (set_err_s)  error_r  <= 1'b1;
    end
  end

  // Output decode from the registered state and latched opcode; ir_load
  // additionally follows mem_ack so the instruction is captured with its ack.
  always_comb begin
    pc_latch_data = 1'b0;
    pc_ctl        = 2'b00;
    ir_load       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    rf_we         = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = fetch_ack_s;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode_r == OP_STORE) ? 1'b1 : 1'b0;
      end
      S_WB: rf_we = 1'b1;
      S_PCUPD: begin
        pc_latch_data = 1'b1;
        case (opcode_r)
          OP_JMP:  pc_ctl = 2'b01;
          OP_BZ:   pc_ctl = zf_r ? 2'b01 : 2'b00;
          OP_JR:   pc_ctl = 2'b10;
          default: pc_ctl = 2'b00;
        endcase
      end
      default: pc_ctl = 2'b00;
    endcase
  end

  assign halted = halted_r;
  assign error  = error_r;
  assign state  = state_r;

endmodule

// File: tb/tb_fsm_ctl.sv
// -----------------------------------------------------------------------------
// tb_fsm_ctl : directed, self-checking bench for fsm_ctl with hand-computed
// expected values. Inputs change 1 time unit after the rising edge; outputs
// are checked there too, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fsm_ctl;

  logic        clka = 1'b0;
  logic        reset;
  logic        run;
  logic        mem_ack;
  logic [15:0] instr;
  logic        zero_flag;
  logic        pc_latch_data;
  logic [1:0]  pc_ctl;
  logic        ir_load;
  logic        mem_req;
  logic        mem_we;
  logic        rf_we;
  logic        halted;
  logic        error;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int pc_pulses = 0;

  fsm_ctl #(.PC_BITS(6), .TIMEOUT(15)) dut (
    .clka          (clka),
    .reset         (reset),
    .run           (run),
    .mem_ack       (mem_ack),
    .instr         (instr),
    .zero_flag     (zero_flag),
    .pc_latch_data (pc_latch_data),
    .pc_ctl        (pc_ctl),
    .ir_load       (ir_load),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .rf_we         (rf_we),
    .halted        (halted),
    .error         (error),
    .state         (state)
  );

  always #5 clka = ~clka;

  // Count PC update strobes mid-cycle.
  always @(negedge clka) begin
    if (pc_latch_data) pc_pulses <= pc_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {8'd0, pc_latch_data, pc_ctl, ir_load, mem_req, mem_we, rf_we, halted},
             16'd0);
    check_eq({tag, "_err"}, {15'd0, error}, 16'd0);
  endtask

  // From FETCH: present word w with an immediate ack, move to DECODE then EXEC.
  task automatic fetch_to_exec(input logic [15:0] w);
    check_eq("fetch_state", {13'd0, state}, 16'd1);
    check_eq("fetch_req", {15'd0, mem_req}, 16'd1);
    instr   = w;
    mem_ack = 1'b1;
    #1;
    check_eq("fetch_ir_load", {15'd0, ir_load}, 16'd1);
    tick();
    mem_ack = 1'b0;
    check_eq("decode_state", {13'd0, state}, 16'd2);
    tick();
    check_eq("exec_state", {13'd0, state}, 16'd3);
  endtask

  // From EXEC of a branch-class op: check PCUPD and return to FETCH.
  task automatic pcupd_check(input string tag, input logic [1:0] exp_ctl);
    tick();
    check_eq({tag, "_pcupd_state"}, {13'd0, state}, 16'd6);
    check_eq({tag, "_pc_latch"}, {15'd0, pc_latch_data}, 16'd1);
    check_eq({tag, "_pc_ctl"}, {14'd0, pc_ctl}, {14'd0, exp_ctl});
    tick();
    check_eq({tag, "_back_fetch"}, {13'd0, state}, 16'd1);
  endtask

  initial begin
    reset     = 1'b0;
    run       = 1'b0;
    mem_ack   = 1'b0;
    instr     = 16'h0000;
    zero_flag = 1'b0;
    #3;
    check_eq("reset_state", {13'd0, state}, 16'd0);
    check_all_zero("reset");
    @(negedge clka);
    reset = 1'b1;
    tick();
    check_eq("idle_hold", {13'd0, state}, 16'd0);
    check_all_zero("idle");

    // ALU: six cycles FETCH..FETCH.
    run = 1'b1;
    tick();
    fetch_to_exec(16'h1234);
    tick();
    check_eq("alu_wb_state", {13'd0, state}, 16'd5);
    check_eq("alu_rf_we", {15'd0, rf_we}, 16'd1);
    pcupd_check("alu", 2'b00);

    // BZ taken then not taken.
    zero_flag = 1'b1;
    fetch_to_exec(16'h4000);
    pcupd_check("bz_taken", 2'b01);
    zero_flag = 1'b0;
    fetch_to_exec(16'h4abc);
    pcupd_check("bz_not", 2'b00);

    // STORE with the ack arriving on the fourth MEM cycle.
    fetch_to_exec(16'h3000);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("store_mem_state", {13'd0, state}, 16'd4);
      check_eq("store_mem_we", {15'd0, mem_we}, 16'd1);
      check_eq("store_rf_we", {15'd0, rf_we}, 16'd0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    check_eq("store_to_pcupd", {13'd0, state}, 16'd6);
    check_eq("store_no_rf_we", {15'd0, rf_we}, 16'd0);
    tick();

    // LOAD: MEM read, then WB.
    fetch_to_exec(16'h2000);
    tick();
    check_eq("load_mem_state", {13'd0, state}, 16'd4);
    check_eq("load_mem_we", {15'd0, mem_we}, 16'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("load_wb_state", {13'd0, state}, 16'd5);
    check_eq("load_rf_we", {15'd0, rf_we}, 16'd1);
    pcupd_check("load", 2'b00);

    // JR, JMP, undefined opcode.
    fetch_to_exec(16'h5000);
    pcupd_check("jr", 2'b10);
    fetch_to_exec(16'h6000);
    pcupd_check("jmp", 2'b01);
    fetch_to_exec(16'h9000);
    pcupd_check("undef", 2'b00);

    // Ack on exactly the 15th FETCH wait cycle: no error.
    for (int i = 0; i < 14; i++) tick();
    check_eq("ack15_still_fetch", {13'd0, state}, 16'd1);
    instr   = 16'h0000;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("ack15_decode", {13'd0, state}, 16'd2);
    check_eq("ack15_no_error", {15'd0, error}, 16'd0);
    tick();
    pcupd_check("nop", 2'b00);

    // Reset asserted in the middle of MEM.
    fetch_to_exec(16'h2000);
    tick();
    check_eq("mid_mem_req", {15'd0, mem_req}, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_state", {13'd0, state}, 16'd0);
    check_all_zero("async_rst");
    @(negedge clka);
    reset = 1'b1;
    tick();
    check_eq("first_edge_fetch", {13'd0, state}, 16'd1);

    // HALT: STOP with halted, no PC strobe, run ignored.
    fetch_to_exec(16'hF000);
    check_eq("halt_exec_no_pc", {15'd0, pc_latch_data}, 16'd0);
    tick();
    check_eq("halt_state", {13'd0, state}, 16'd7);
    check_eq("halt_flag", {15'd0, halted}, 16'd1);
    check_eq("halt_no_error", {15'd0, error}, 16'd0);
    check_eq("halt_no_pc", {15'd0, pc_latch_data}, 16'd0);
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    check_eq("stop_terminal", {13'd0, state}, 16'd7);
    check_eq("stop_halt_held", {15'd0, halted}, 16'd1);

    // Timeout: no ack in FETCH for 15 cycles.
    reset = 1'b0;
    #2;
    check_eq("rst_clears_halt", {15'd0, halted}, 16'd0);
    @(negedge clka);
    reset = 1'b1;
    tick();
    check_eq("to_fetch", {13'd0, state}, 16'd1);
    for (int i = 0; i < 14; i++) tick();
    check_eq("to_cycle15_fetch", {13'd0, state}, 16'd1);
    check_eq("to_cycle15_no_err", {15'd0, error}, 16'd0);
    tick();
    check_eq("to_state", {13'd0, state}, 16'd7);
    check_eq("to_error", {15'd0, error}, 16'd1);
    check_eq("to_mem_req", {15'd0, mem_req}, 16'd0);
    check_eq("to_not_halted", {15'd0, halted}, 16'd0);
    tick();
    check_eq("to_error_held", {15'd0, error}, 16'd1);

    // Nine instructions completed, one PC strobe each.
    check_eq("pc_pulse_count", 16'(pc_pulses), 16'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
